// File: rtl/bus_pkg.sv
// Shared bus width-conversion types, default widths and ratio helpers.
// Used by the downsizer and its beat counter (and the matching upsizer).
package bus_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } state_t;

  localparam int BUS_NARROW_W = 8;
  localparam int BUS_WIDE_W   = 32;

  function automatic int bus_ratio(input int wide, input int narrow);
    return wide / narrow;
  endfunction

  function automatic int bus_idx_w(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/bus_beat_counter.sv
// Modulo-R beat index: load clears to 0, inc advances and wraps after R-1.
// Ports: clock, reset (async active-low), inc, load, idx, is_last.
module bus_beat_counter
  import bus_pkg::*;
#(
  parameter int R  = 4,
  parameter int IW = bus_idx_w(R)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inc,
  input  logic          load,
  output logic [IW-1:0] idx,
  output logic          is_last
);

  assign is_last = (idx == IW'(R - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx <= '0;
    end else if (load) begin
      idx <= '0;
    end else if (inc) begin
      idx <= is_last ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/bus_downsizer.sv
// Splits each wide slave word into R narrow master beats, full throughput.
// Ports: clock, reset (async active-low), s_val/s_data/s_rdy, m_val/m_data/m_rdy/m_last.
// Macro BUS_DOWNSIZER_MSB_FIRST_EN reverses beat order (MSB beat first).
module bus_downsizer
  import bus_pkg::*;
#(
  parameter int S_DATA_WIDTH = BUS_WIDE_W,
  parameter int M_DATA_WIDTH = BUS_NARROW_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    s_val,
  input  logic [S_DATA_WIDTH-1:0] s_data,
  output logic                    s_rdy,
  output logic                    m_val,
  output logic [M_DATA_WIDTH-1:0] m_data,
  input  logic                    m_rdy,
  output logic                    m_last
);

  localparam int R  = bus_ratio(S_DATA_WIDTH, M_DATA_WIDTH);
  localparam int IW = bus_idx_w(R);

  if (((S_DATA_WIDTH % M_DATA_WIDTH) != 0) || (R < 2)) begin : g_illegal
    $error("bus_downsizer: S_DATA_WIDTH must be a multiple of M_DATA_WIDTH with R >= 2");
  end

  state_t                  state;
  logic [S_DATA_WIDTH-1:0] word;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           sel;
  logic                    is_last;
  logic                    s_xfer;
  logic                    m_xfer;
  logic [M_DATA_WIDTH-1:0] beats [R];

  assign m_val  = (state == SEND);
  assign m_xfer = m_val && m_rdy;
  assign s_xfer = s_val && s_rdy;

  // Refill on the same edge the last beat leaves, so words stream gap-free.
  assign s_rdy = reset &&
                 ((state == EMPTY) ||
                  ((state == SEND) && is_last && m_rdy));

  assign m_last = m_val && is_last;

  bus_beat_counter #(
    .R  (R),
    .IW (IW)
  ) u_cnt (
    .clock   (clock),
    .reset   (reset),
    .inc     (m_xfer),
    .load    (s_xfer),
    .idx     (idx),
    .is_last (is_last)
  );

  for (genvar g = 0; g < R; g++) begin : g_beat
    assign beats[g] = word[g*M_DATA_WIDTH +: M_DATA_WIDTH];
  end

`ifdef BUS_DOWNSIZER_MSB_FIRST_EN
  assign sel = IW'(R - 1) - idx;
`else
  assign sel = idx;
`endif

  assign m_data = beats[sel];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
      word  <= '0;
    end else begin
      if (s_xfer) begin
        word <= s_data;
      end
      unique case (state)
        EMPTY: begin
          if (s_xfer) state <= SEND;
        end
        SEND: begin
          if (m_xfer && is_last && !s_xfer) state <= EMPTY;
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_downsizer.sv
// Directed self-checking bench for bus_downsizer (32-bit to 8-bit).
// Beat order follows BUS_DOWNSIZER_MSB_FIRST_EN when defined.
module tb_bus_downsizer;

  logic        clock = 1'b0;
  logic        reset;
  logic        s_val;
  logic [31:0] s_data;
  logic        s_rdy;
  logic        m_val;
  logic [7:0]  m_data;
  logic        m_rdy;
  logic        m_last;

  int errors = 0;
  int checks = 0;

  bus_downsizer #(
    .S_DATA_WIDTH (32),
    .M_DATA_WIDTH (8)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .s_val  (s_val),
    .s_data (s_data),
    .s_rdy  (s_rdy),
    .m_val  (m_val),
    .m_data (m_data),
    .m_rdy  (m_rdy),
    .m_last (m_last)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] beat(input logic [31:0] w, input int i);
    int k;
`ifdef BUS_DOWNSIZER_MSB_FIRST_EN
    k = 3 - i;
`else
    k = i;
`endif
    return w[k*8 +: 8];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] w,
                          input int i, input logic rdy_exp);
    check({tag, " m_val"}, 32'(m_val), 32'd1);
    check({tag, " m_data"}, 32'(m_data), 32'(beat(w, i)));
    check({tag, " m_last"}, 32'(m_last), 32'(i == 3));
    check({tag, " s_rdy"}, 32'(s_rdy), 32'(rdy_exp));
  endtask

  task automatic chk_idle(input string tag);
    check({tag, " m_val"}, 32'(m_val), 32'd0);
    check({tag, " m_last"}, 32'(m_last), 32'd0);
    check({tag, " s_rdy"}, 32'(s_rdy), 32'd1);
  endtask

  initial begin
    logic [31:0] w0;
    logic [31:0] w1;

    reset  = 1'b0;
    s_val  = 1'b0;
    s_data = 32'hFFFF_FFFF;
    m_rdy  = 1'b0;
    #1;
    check("rst m_val", 32'(m_val), 32'd0);
    check("rst m_data", 32'(m_data), 32'd0);
    check("rst m_last", 32'(m_last), 32'd0);
    check("rst s_rdy", 32'(s_rdy), 32'd0);

    #11 reset = 1'b1;
    @(negedge clock);
    #1 chk_idle("post rst");

    // Single word, then idle slave
    w0 = 32'h0403_0201;
    @(negedge clock);
    s_val = 1'b1; s_data = w0; m_rdy = 1'b1;
    #1 check("single accept s_rdy", 32'(s_rdy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      s_val = 1'b0; s_data = 32'hDEAD_BEEF;
      #1 chk_beat("single", w0, i, i == 3);
    end
    @(negedge clock);
    #1 chk_idle("idle after word");

    // Back-to-back words, no gap
    w0 = 32'h4433_2211;
    w1 = 32'h8877_6655;
    @(negedge clock);
    s_val = 1'b1; s_data = w0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (k == 0) s_data = w1;
      if (k == 4) begin
        s_val = 1'b0; s_data = 32'h0;
      end
      #1 chk_beat("b2b", (k < 4) ? w0 : w1, k % 4, (k % 4) == 3);
    end
    @(negedge clock);
    #1 chk_idle("idle after b2b");

    // Backpressure on beat 1
    @(negedge clock);
    s_val = 1'b1; s_data = w0;
    @(negedge clock);
    s_val = 1'b1; s_data = w1;
    #1 chk_beat("bp beat0", w0, 0, 1'b0);
    @(negedge clock);
    m_rdy = 1'b0;
    #1 chk_beat("bp beat1", w0, 1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1 chk_beat("bp hold", w0, 1, 1'b0);
    end
    m_rdy = 1'b1;
    s_val = 1'b0;
    #1 chk_beat("bp release", w0, 1, 1'b0);
    for (int i = 2; i < 4; i++) begin
      @(negedge clock);
      #1 chk_beat("bp resume", w0, i, i == 3);
    end
    @(negedge clock);
    #1 chk_idle("idle after bp");

    // Asynchronous reset mid-word
    w0 = 32'h0403_0201;
    @(negedge clock);
    s_val = 1'b1; s_data = w0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      s_val = 1'b0;
      #1 chk_beat("pre rst", w0, i, 1'b0);
    end
    #1 reset = 1'b0;
    #1;
    check("async rst m_val", 32'(m_val), 32'd0);
    check("async rst m_data", 32'(m_data), 32'd0);
    check("async rst s_rdy", 32'(s_rdy), 32'd0);
    @(posedge clock);
    #2 reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1 chk_idle("after rst");
    end

    w1 = 32'hDDCC_BBAA;
    @(negedge clock);
    s_val = 1'b1; s_data = w1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      s_val = 1'b0;
      #1 chk_beat("post rst word", w1, i, i == 3);
    end
    @(negedge clock);
    #1 chk_idle("final idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_downsizer.md
Name: bus_downsizer

Overview:
- Width-reducing stream stage: accepts one wide word per valid/ready handshake and emits it as R narrow beats on a valid/ready master port.
- Pairs with the bus upsizer: sits downstream of it, restoring the narrow stream (e.g. 32-bit back to 8-bit).
- Sustains full throughput, so back-to-back words leave no idle cycles on the master side.

Parameters:
- S_DATA_WIDTH, 32, slave (input) word width.
- M_DATA_WIDTH, 8, master (output) beat width.
- R (localparam), S_DATA_WIDTH/M_DATA_WIDTH, beats per word.
- Legality: S_DATA_WIDTH must be a multiple of M_DATA_WIDTH and R >= 2. Otherwise elaboration fails via a generate-time error.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (reset == 0 clears state immediately).
- s_val  input  1  slave word valid.
- s_data  input  S_DATA_WIDTH  slave word.
- s_rdy  output  1  slave ready.
- m_val  output  1  master beat valid.
- m_data  output  M_DATA_WIDTH  current narrow beat.
- m_rdy  input  1  master ready.
- m_last  output  1  high with the final beat of a word.

Behaviour:
- Reset values while reset == 0:
  - m_val = 0, m_data = 0, m_last = 0, s_rdy = 0.
  - Word register = 0, beat index = 0, state = EMPTY.
- States:
  - EMPTY: no word held. m_val = 0, s_rdy = 1.
  - SEND: word held. m_val = 1.
- Handshakes:
  - Slave transfer occurs when s_val && s_rdy at a rising edge.
  - Master transfer occurs when m_val && m_rdy at a rising edge.
- s_rdy = (state == EMPTY) || (state == SEND && idx == R-1 && m_rdy).
  - This is a combinational path from m_rdy to s_rdy, and it is intentional: a new word loads on the same edge that the last beat leaves.
- EMPTY -> SEND on a slave transfer: word captured, idx = 0.
- SEND:
  - Master transfer with idx < R-1: idx increments.
  - Master transfer with idx == R-1 and a simultaneous slave transfer: new word captured, idx = 0, stays in SEND.
  - Master transfer with idx == R-1 and no slave transfer: -> EMPTY.
- Beat selection, default LSB-first: m_data = word[idx*M +: M].
- m_last = m_val && (idx == R-1).
- Latency: a word accepted at edge k presents beat 0 on m_data/m_val after edge k, one cycle later.
- Throughput: one beat per cycle while m_rdy = 1; a new word every R cycles.
- Backpressure: while m_val = 1 and m_rdy = 0, m_data, m_last and idx hold stable (AXI-style stability).
- m_val never drops without a master transfer.
- s_data is ignored except at a slave transfer.
- Asynchronous reset mid-word: the partial word is discarded, with no further beats after release. The first edge after release can accept a word.
- Index counter width is $clog2(R); it never wraps past R-1.

Optional Feature:
- Macro: BUS_DOWNSIZER_MSB_FIRST_EN.
- Defined: beat order reversed, m_data = word[(R-1-idx)*M +: M]. m_last is still the R-th beat.
- Undefined: LSB-first order as above.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package bus_pkg:
  - State enum (EMPTY, SEND).
  - Default width constants BUS_NARROW_W = 8, BUS_WIDE_W = 32.
  - Ratio helper function shared with the upsizer.
- One sub-module: bus_beat_counter.
  - Ports: clock, reset, inc, load, idx, is_last.
  - Modulo-R index; reused by the upsizer.
- Mux and FSM stay in bus_downsizer.

Test Plan:
- Reset then single word: s_data = 0x04030201 with m_rdy = 1.
  - Beats 0x01, 0x02, 0x03, 0x04 on four consecutive cycles; m_last only on 0x04.
  - s_rdy = 0 during beats 0..2.
- Back-to-back: words 0x44332211 and 0x88776655 held valid, m_rdy = 1.
  - Eight consecutive beats 11..88 with no m_val gap.
  - Second word accepted on the same edge as beat 0x44.
- Backpressure: m_rdy = 0 for 3 cycles after beat 0x22 appears.
  - m_data holds 0x22, m_val stays 1, s_rdy stays 0.
  - Stream resumes with 0x33 once m_rdy = 1.
- Reset mid-word: assert reset = 0 after beat 0x02 of 0x04030201.
  - m_val = 0 immediately (asynchronous), no 0x03/0x04 after release.
  - Next word 0xDDCCBBAA emits AA first.
- Idle slave: s_val = 0 after one word.
  - State returns to EMPTY; m_val = 0 and s_rdy = 1 the cycle after beat 0x04.
- With BUS_DOWNSIZER_MSB_FIRST_EN defined: word 0x04030201.
  - Beats 0x04, 0x03, 0x02, 0x01; m_last on 0x01.
